// File: rtl/conv1d_sequencer_if.sv
// rtl/conv1d_sequencer_if.sv - conv1d command port and result stream bundle
//
// Purpose: groups the conv1d CFU command port (cv_*) and the result
//          valid/ready stream (out_*) driven by the sequencer.
// Ports (master = sequencer side):
//   cv_en, cv_cmd, cv_inp0, cv_inp1  out  command issued this cycle
//   cv_ret                           in   response to the previous cycle's command
//   out_valid, out_data, out_ch      out  quantised result and its channel
//   out_ready                        in   downstream accept
interface conv1d_sequencer_if #(
    parameter int INT32_SIZE = 32,
    parameter int CH_W       = 8
);
    logic                  cv_en;
    logic [6:0]            cv_cmd;
    logic [INT32_SIZE-1:0] cv_inp0;
    logic [INT32_SIZE-1:0] cv_inp1;
    logic [INT32_SIZE-1:0] cv_ret;
    logic                  out_valid;
    logic                  out_ready;
    logic [INT32_SIZE-1:0] out_data;
    logic [CH_W-1:0]       out_ch;

    modport master (
        output cv_en, cv_cmd, cv_inp0, cv_inp1,
        input  cv_ret,
        output out_valid, out_data, out_ch,
        input  out_ready
    );

    modport slave (
        input  cv_en, cv_cmd, cv_inp0, cv_inp1,
        output cv_ret,
        input  out_valid, out_data, out_ch,
        output out_ready
    );
endinterface

// File: rtl/conv1d_sequencer.sv
// rtl/conv1d_sequencer.sv - conv1d CFU sequencer for one output position over all channels
//
// Purpose: loads the conv1d config once, then per output channel streams kernel
//          words and quant params from external memories, starts the MAC, polls
//          for completion, reads the result and emits it on a valid/ready port.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               1-cycle request, sampled only in IDLE
//   busy, done, err     run status; err is sticky until the next start
//   cfg_*               run configuration, latched on start
//   wt_addr / wt_data   kernel memory (data valid one cycle after address)
//   prm_addr / prm_data param memory (data valid one cycle after address)
//   bus                 conv1d command port and result stream
module conv1d_sequencer #(
    parameter int INT32_SIZE   = 32,
    parameter int CH_W         = 8,
    parameter int POLL_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [INT32_SIZE-1:0] cfg_in_depth,
    input  logic [CH_W-1:0]       cfg_out_ch,
    input  logic [INT32_SIZE-1:0] cfg_start_x,
    input  logic [INT32_SIZE-1:0] cfg_in_off,
    input  logic [INT32_SIZE-1:0] cfg_act_min,
    input  logic [INT32_SIZE-1:0] cfg_act_max,
    input  logic [INT32_SIZE-1:0] cfg_out_off,
    output logic [INT32_SIZE-1:0] wt_addr,
    input  logic [INT32_SIZE-1:0] wt_data,
    output logic [INT32_SIZE-1:0] prm_addr,
    input  logic [INT32_SIZE-1:0] prm_data,
    conv1d_sequencer_if.master    bus
);
    localparam int PW = $clog2(POLL_TIMEOUT + 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CFG   = 4'd1;
    localparam logic [3:0] S_LDW   = 4'd2;
    localparam logic [3:0] S_LDP   = 4'd3;
    localparam logic [3:0] S_START = 4'd4;
    localparam logic [3:0] S_POLL  = 4'd5;
    localparam logic [3:0] S_RD    = 4'd6;
    localparam logic [3:0] S_OUT   = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    logic [3:0]            state;
    logic [8:0]            idx;
    logic [PW-1:0]         poll_cnt;
    logic [INT32_SIZE-1:0] depth_q, start_x_q, in_off_q, act_min_q, act_max_q, out_off_q;
    logic [INT32_SIZE-1:0] wt_base, prm_base, out_data_q;
    logic [CH_W-1:0]       n_ch_q, ch, out_ch_q;
    logic                  err_q;
    logic [8:0]            wt_len;
    logic                  depth_ok;

    // depth is bounded to 128, so 2*depth fits the 9-bit step counter
    assign wt_len   = {depth_q[7:0], 1'b0};
    assign depth_ok = !cfg_in_depth[0] && (cfg_in_depth != '0)
                      && (cfg_in_depth <= INT32_SIZE'(128));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            poll_cnt   <= '0;
            depth_q    <= '0;
            start_x_q  <= '0;
            in_off_q   <= '0;
            act_min_q  <= '0;
            act_max_q  <= '0;
            out_off_q  <= '0;
            wt_base    <= '0;
            prm_base   <= '0;
            out_data_q <= '0;
            n_ch_q     <= '0;
            ch         <= '0;
            out_ch_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    depth_q   <= cfg_in_depth;
                    n_ch_q    <= cfg_out_ch;
                    start_x_q <= cfg_start_x;
                    in_off_q  <= cfg_in_off;
                    act_min_q <= cfg_act_min;
                    act_max_q <= cfg_act_max;
                    out_off_q <= cfg_out_off;
                    idx       <= '0;
                    err_q     <= !depth_ok;
                    if (!depth_ok || cfg_out_ch == '0) state <= S_DONE;
                    else                                state <= S_CFG;
                end
                S_CFG: begin
                    if (idx == 9'd6) begin
                        idx      <= '0;
                        ch       <= '0;
                        wt_base  <= '0;
                        prm_base <= '0;
                        state    <= S_LDW;
                    end else begin
                        idx <= idx + 9'd1;
                    end
                end
                S_LDW: begin
                    if (idx == wt_len) begin
                        idx   <= '0;
                        state <= S_LDP;
                    end else begin
                        idx <= idx + 9'd1;
                    end
                end
                S_LDP: begin
                    if (idx == 9'd3) begin
                        idx   <= '0;
                        state <= S_START;
                    end else begin
                        idx <= idx + 9'd1;
                    end
                end
                S_START: begin
                    poll_cnt <= '0;
                    state    <= S_POLL;
                end
                S_POLL: begin
                    poll_cnt <= poll_cnt + 1'b1;
                    // the first poll cycle still sees the response to cmd 6
                    if (poll_cnt != '0 && bus.cv_ret[0]) begin
                        idx   <= '0;
                        state <= S_RD;
                    end else if (poll_cnt == PW'(POLL_TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_RD: begin
                    // step 0 issues cmd 7, step 1 sees its response
                    if (idx == '0) begin
                        idx <= 9'd1;
                    end else begin
                        idx        <= '0;
                        out_data_q <= bus.cv_ret;
                        out_ch_q   <= ch;
                        state      <= S_OUT;
                    end
                end
                S_OUT: if (bus.out_ready) begin
                    ch       <= ch + CH_W'(1);
                    wt_base  <= wt_base + INT32_SIZE'(wt_len);
                    prm_base <= prm_base + INT32_SIZE'(3);
                    if ((ch + CH_W'(1)) == n_ch_q) state <= S_DONE;
                    else                           state <= S_LDW;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.cv_en     = 1'b0;
        bus.cv_cmd    = 7'd0;
        bus.cv_inp0   = '0;
        bus.cv_inp1   = '0;
        bus.out_valid = 1'b0;
        wt_addr       = '0;
        prm_addr      = '0;
        case (state)
            S_CFG: begin
                bus.cv_en = 1'b1;
                case (idx)
                    9'd0:    begin bus.cv_cmd = 7'd18; bus.cv_inp1 = INT32_SIZE'(4); end
                    9'd1:    begin bus.cv_cmd = 7'd3;  bus.cv_inp1 = in_off_q;  end
                    9'd2:    begin bus.cv_cmd = 7'd5;  bus.cv_inp1 = depth_q;   end
                    9'd3:    begin bus.cv_cmd = 7'd8;  bus.cv_inp1 = start_x_q; end
                    9'd4:    begin bus.cv_cmd = 7'd15; bus.cv_inp1 = act_min_q; end
                    9'd5:    begin bus.cv_cmd = 7'd16; bus.cv_inp1 = act_max_q; end
                    default: begin bus.cv_cmd = 7'd17; bus.cv_inp1 = out_off_q; end
                endcase
            end
            S_LDW: begin
                // address leads the cmd-2 write of the same word by one cycle
                bus.cv_en = 1'b1;
                if (idx < wt_len) wt_addr = wt_base + INT32_SIZE'(idx);
                if (idx == '0) begin
                    bus.cv_cmd = 7'd9;
                end else begin
                    bus.cv_cmd  = 7'd2;
                    bus.cv_inp0 = INT32_SIZE'(idx - 9'd1) << 2;
                    bus.cv_inp1 = wt_data;
                end
            end
            S_LDP: begin
                bus.cv_en = 1'b1;
                if (idx < 9'd3) prm_addr = prm_base + INT32_SIZE'(idx);
                if (idx == '0) begin
                    bus.cv_cmd = 7'd9;
                end else begin
                    bus.cv_cmd  = 7'd11 + 7'(idx);
                    bus.cv_inp1 = prm_data;
                end
            end
            S_START: begin
                bus.cv_en  = 1'b1;
                bus.cv_cmd = 7'd6;
            end
            S_POLL: begin
                bus.cv_en  = 1'b1;
                bus.cv_cmd = 7'd9;
            end
            S_RD: begin
                bus.cv_en  = 1'b1;
                bus.cv_cmd = (idx == '0) ? 7'd7 : 7'd9;
            end
            S_OUT: begin
                bus.cv_en     = 1'b1;
                bus.cv_cmd    = 7'd9;
                bus.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign done         = (state == S_DONE);
    assign err          = err_q;
    assign bus.out_data = out_data_q;
    assign bus.out_ch   = out_ch_q;
endmodule

// File: tb/tb_conv1d_sequencer.sv
// tb/tb_conv1d_sequencer.sv - directed self-checking bench for conv1d_sequencer
module tb_conv1d_sequencer;
    localparam int PT = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [31:0] cfg_in_depth = 32'd2;
    logic [7:0]  cfg_out_ch = 8'd1;
    logic [31:0] cfg_start_x = 32'd7;
    logic [31:0] cfg_in_off = 32'd128;
    logic [31:0] cfg_act_min = 32'hFFFF_FF80;
    logic [31:0] cfg_act_max = 32'd127;
    logic [31:0] cfg_out_off = 32'd3;
    logic [31:0] wt_addr, prm_addr;
    logic [31:0] wt_data = '0;
    logic [31:0] prm_data = '0;

    always #5 clk = ~clk;

    conv1d_sequencer_if #(.INT32_SIZE(32), .CH_W(8)) bus ();

    conv1d_sequencer #(.INT32_SIZE(32), .CH_W(8), .POLL_TIMEOUT(PT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .cfg_in_depth(cfg_in_depth), .cfg_out_ch(cfg_out_ch), .cfg_start_x(cfg_start_x),
        .cfg_in_off(cfg_in_off), .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
        .cfg_out_off(cfg_out_off), .wt_addr(wt_addr), .wt_data(wt_data),
        .prm_addr(prm_addr), .prm_data(prm_data), .bus(bus.master)
    );

    int vectors = 0;
    int miscompares = 0;

    // conv1d stub and memories: command of the cycle is observed at the
    // falling edge, its response appears after the next rising edge
    logic [31:0] s_wsum = '0, s_bias = '0, ret_nx = '0, wa_s = '0, pa_s = '0;
    int          s_polls = 0, finish_delay = 2, n_cmd6 = 0, done_cnt = 0;
    logic [31:0] inp0_q[$];
    int          trace[$];
    logic [31:0] res_d[$];
    logic [7:0]  res_c[$];

    function automatic logic [31:0] prm_word(input logic [31:0] a);
        case (a % 3)
            0:       return 100 * (a / 3) + 5;
            1:       return 32'h4000_0000;
            default: return 32'd1;
        endcase
    endfunction

    always @(negedge clk) begin
        wa_s   = wt_addr;
        pa_s   = prm_addr;
        ret_nx = '0;
        if (done) done_cnt++;
        if (bus.cv_en) begin
            if (bus.cv_cmd != 7'd9) trace.push_back(int'(bus.cv_cmd));
            case (bus.cv_cmd)
                7'd18: s_wsum = '0;
                7'd2:  begin s_wsum += bus.cv_inp1; inp0_q.push_back(bus.cv_inp0); end
                7'd12: s_bias = bus.cv_inp1;
                7'd6:  begin s_polls = 0; n_cmd6++; end
                7'd9:  begin ret_nx = 32'(s_polls >= finish_delay); s_polls++; end
                7'd7:  begin ret_nx = s_wsum + s_bias; s_wsum = '0; end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        bus.cv_ret <= ret_nx;
        wt_data    <= wa_s * 3 + 1;
        prm_data   <= prm_word(pa_s);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {23'd0, busy, done, err, bus.cv_en, bus.cv_cmd, bus.out_valid}, 32'd0);
        chk({tag, "_bus"}, wt_addr | prm_addr | bus.out_data | bus.cv_inp0 | bus.cv_inp1, 32'd0);
    endtask

    task automatic start_run(input logic [31:0] depth, input logic [7:0] nch);
        @(negedge clk);
        inp0_q.delete(); trace.delete(); res_d.delete(); res_c.delete();
        done_cnt = 0; n_cmd6 = 0;
        cfg_in_depth = depth;
        cfg_out_ch   = nch;
        start        = 1'b1;
    endtask

    // runs until done, holding each result unaccepted for `hold` cycles
    task automatic wait_done(input int hold, input bit keep_start, input int budget,
                             output bit ok, output int n);
        logic [31:0] d0;
        logic [7:0]  c0;
        bit          stable;
        ok = 1'b0;
        n  = 0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (!keep_start) start = 1'b0;
            bus.out_ready = (hold == 0);
            if (done) begin
                ok    = 1'b1;
                start = 1'b0;
            end else if (bus.out_valid) begin
                if (hold > 0) begin
                    d0 = bus.out_data; c0 = bus.out_ch; stable = 1'b1;
                    repeat (hold) begin
                        @(negedge clk);
                        n++;
                        if (bus.out_data !== d0 || bus.out_ch !== c0 || !bus.out_valid
                            || bus.cv_cmd !== 7'd9) stable = 1'b0;
                    end
                    chk("hold_stable", 32'(stable), 32'd1);
                    bus.out_ready = 1'b1;
                end
                res_d.push_back(bus.out_data);
                res_c.push_back(bus.out_ch);
            end
        end
        chk("finished", 32'(ok), 32'd1);
    endtask

    initial begin
        bit ok;
        int n;
        bit tr_ok;
        int exp_tr[16] = '{18, 3, 5, 8, 15, 16, 17, 2, 2, 2, 2, 12, 13, 14, 6, 7};
        logic [31:0] exp2[3] = '{32'd97, 32'd389, 32'd681};

        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;

        // 1: depth 2, one channel
        start_run(32'd2, 8'd1);
        wait_done(0, 1'b0, 300, ok, n);
        chk("t1_nwr", 32'(inp0_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < inp0_q.size(); i++) chk("t1_inp0", inp0_q[i], 32'(4 * i));
        chk("t1_nres", 32'(res_d.size()), 32'd1);
        if (res_d.size() == 1) begin
            chk("t1_data", res_d[0], 32'd27);
            chk("t1_ch", 32'(res_c[0]), 32'd0);
        end
        tr_ok = (trace.size() == 16);
        for (int i = 0; i < 16 && i < trace.size(); i++) if (trace[i] != exp_tr[i]) tr_ok = 1'b0;
        chk("t1_trace", 32'(tr_ok), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_ndone", 32'(done_cnt), 32'd1);

        // 2: depth 4, three channels, back-pressure
        start_run(32'd4, 8'd3);
        wait_done(10, 1'b0, 2000, ok, n);
        chk("t2_nres", 32'(res_d.size()), 32'd3);
        for (int i = 0; i < 3 && i < res_d.size(); i++) begin
            chk("t2_data", res_d[i], exp2[i]);
            chk("t2_ch", 32'(res_c[i]), 32'(i));
        end

        // 3: bad depth, zero channels
        start_run(32'd3, 8'd1);
        wait_done(0, 1'b0, 10, ok, n);
        chk("t3_latency_ok", 32'(n <= 2), 32'd1);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_ncmd6", 32'(n_cmd6), 32'd0);
        start_run(32'd4, 8'd0);
        wait_done(0, 1'b0, 10, ok, n);
        chk("t3_zero_err", 32'(err), 32'd0);
        chk("t3_zero_ncmd6", 32'(n_cmd6), 32'd0);

        // 4: poll timeout, then err cleared by next start
        finish_delay = 1000000;
        start_run(32'd2, 8'd1);
        wait_done(0, 1'b0, 500, ok, n);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_polls", 32'(s_polls), 32'(PT));
        chk("t4_nres", 32'(res_d.size()), 32'd0);
        finish_delay = 2;
        start_run(32'd2, 8'd1);
        @(negedge clk);
        start = 1'b0;
        chk("t4_err_clr", 32'(err), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        wait_done(0, 1'b0, 300, ok, n);
        chk("t4_rerun", (res_d.size() == 1) ? res_d[0] : 32'hDEAD, 32'd27);

        // 5: reset during LDW and during OUT
        start_run(32'd4, 8'd2);
        n = 0;
        do begin @(negedge clk); start = 1'b0; n++; end while (bus.cv_cmd !== 7'd2 && n < 50);
        chk("t5_reach_ldw", 32'(bus.cv_cmd), 32'd2);
        #2 rst_n = 1'b0;
        #1 chk_quiet("t5_rst_ldw");
        @(negedge clk) rst_n = 1'b1;
        start_run(32'd2, 8'd1);
        wait_done(0, 1'b0, 300, ok, n);
        chk("t5_after_ldw", (res_d.size() == 1) ? res_d[0] : 32'hDEAD, 32'd27);
        start_run(32'd2, 8'd1);
        bus.out_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); start = 1'b0; n++; end while (!bus.out_valid && n < 100);
        chk("t5_reach_out", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_quiet("t5_rst_out");
        @(negedge clk) rst_n = 1'b1;
        start_run(32'd2, 8'd1);
        wait_done(0, 1'b0, 300, ok, n);
        chk("t5_after_out_n", 32'(res_d.size()), 32'd1);
        chk("t5_after_out", (res_d.size() == 1) ? res_d[0] : 32'hDEAD, 32'd27);

        // 6: start held high for the whole run
        start_run(32'd2, 8'd2);
        wait_done(0, 1'b1, 400, ok, n);
        repeat (3) @(negedge clk);
        chk("t6_ndone", 32'(done_cnt), 32'd1);
        chk("t6_nres", 32'(res_d.size()), 32'd2);
        if (res_d.size() == 2) begin
            chk("t6_d0", res_d[0], 32'd27);
            chk("t6_d1", res_d[1], 32'd175);
        end
        chk("t6_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
